// File: rtl/reg_bank_loader.sv
// Write controller for the NUMxBITS enable-register bank: streams a burst into
// registers 0..NUM-1 in order, or performs a single addressed write when idle.
//
// state | meaning
// IDLE  | waiting; single addressed writes accepted unless start is high
// LOAD  | accepting burst words, one per handshake, into register ptr
// DONE  | one-cycle frame completion, frame_done high
module reg_bank_loader #(
   parameter int unsigned BITS = 32,
   parameter int unsigned NUM = 7,
   localparam int unsigned PTR_W = $clog2(NUM)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [BITS-1:0]  s_data,
   input  logic             w_valid,
   output logic             w_ready,
   input  logic [PTR_W-1:0] w_addr,
   input  logic [BITS-1:0]  w_data,
   output logic [NUM-1:0]   en,
   output logic [BITS-1:0]  d,
   output logic             busy,
   output logic             frame_done,
   output logic             addr_err,
   output logic [PTR_W-1:0] ptr
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM - 1);
   localparam logic [NUM-1:0]   ONE = {{(NUM-1){1'b0}}, 1'b1};

   state_t state, state_nxt;
   logic   s_acc, w_acc, w_in_range, at_last;

   assign s_acc      = s_valid & s_ready;
   assign w_acc      = w_valid & w_ready;
   assign w_in_range = 32'(w_addr) < NUM;
   assign at_last    = (ptr == LAST_PTR);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    if (s_acc && at_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_comb begin
      s_ready = (state == LOAD);
      w_ready = (state == IDLE) && !start;
      busy    = (state != IDLE);
   end

   // Abort wins over any handshake in the same cycle, so nothing is written.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         en         <= '0;
         d          <= '0;
         ptr        <= '0;
         frame_done <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         en         <= '0;
         frame_done <= 1'b0;
         addr_err   <= 1'b0;
         if (abort) begin
            ptr <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     ptr <= '0;
                  end else if (w_acc) begin
                     if (w_in_range) begin
                        en <= ONE << w_addr;
                        d  <= w_data;
                     end else begin
                        addr_err <= 1'b1;
                     end
                  end
               end
               LOAD: begin
                  if (s_acc) begin
                     en <= ONE << ptr;
                     d  <= s_data;
                     if (at_last) begin
                        ptr        <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        ptr <= ptr + PTR_W'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_loader.sv
// Directed bench for reg_bank_loader: bursts, stalls, single writes, abort, reset.
module tb_reg_bank_loader;

   logic        clk = 1'b0;
   logic        reset_n, start, abort, s_valid, w_valid;
   logic        s_ready, w_ready, busy, frame_done, addr_err;
   logic [31:0] s_data, w_data, d;
   logic [2:0]  w_addr, ptr;
   logic [6:0]  en;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_bank_loader #(.BITS(32), .NUM(7)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
      .en(en), .d(d), .busy(busy), .frame_done(frame_done),
      .addr_err(addr_err), .ptr(ptr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; w_valid = 1'b0;
      s_data = '0; w_data = '0; w_addr = '0;
      step(); step();
      reset_n = 1'b1;
      #1;
      checks++;
      if (en !== 7'h00 || d !== 32'h0 || ptr !== 3'd0 || frame_done !== 1'b0 || addr_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs en=%h d=%h ptr=%0d fd=%b ae=%b want 00/0/0/0/0", en, d, ptr, frame_done, addr_err);
      end
      checks++;
      if (s_ready !== 1'b0 || w_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_comb s_ready=%b w_ready=%b busy=%b want 0/1/0", s_ready, w_ready, busy);
      end
   endtask

   task automatic test_burst();
      int fd_count = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || s_ready !== 1'b1 || w_ready !== 1'b0 || ptr !== 3'd0) begin
         errors++;
         $display("FAIL burst_enter busy=%b s_ready=%b w_ready=%b ptr=%0d want 1/1/0/0", busy, s_ready, w_ready, ptr);
      end
      s_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         logic [6:0] exp_en;
         logic [2:0] exp_ptr;
         exp_en  = 7'h01 << i;
         exp_ptr = (i == 6) ? 3'd0 : 3'(i + 1);
         s_data = 32'hA0 + 32'(i);
         step();
         if (frame_done === 1'b1) fd_count++;
         checks++;
         if (en !== exp_en || d !== 32'hA0 + 32'(i) || ptr !== exp_ptr || frame_done !== (i == 6)) begin
            errors++;
            $display("FAIL burst_word%0d en=%h d=%h ptr=%0d fd=%b want %h/%h/%0d/%b",
                     i, en, d, ptr, frame_done, exp_en, 32'hA0 + 32'(i), exp_ptr, (i == 6));
         end
      end
      s_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL burst_done_state busy=%b s_ready=%b want 1/0", busy, s_ready);
      end
      step();
      if (frame_done === 1'b1) fd_count++;
      checks++;
      if (busy !== 1'b0 || en !== 7'h00 || fd_count != 1 || d !== 32'hA6) begin
         errors++;
         $display("FAIL burst_after busy=%b en=%h fd_pulses=%0d d=%h want 0/00/1/a6", busy, en, fd_count, d);
      end
   endtask

   task automatic test_stall();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         logic [6:0] exp_en;
         logic [2:0] exp_ptr;
         exp_en  = 7'h01 << i;
         exp_ptr = (i == 6) ? 3'd0 : 3'(i + 1);
         s_valid = 1'b1;
         s_data  = 32'hB0 + 32'(i);
         step();
         s_valid = 1'b0;
         checks++;
         if (en !== exp_en || d !== 32'hB0 + 32'(i) || ptr !== exp_ptr || frame_done !== (i == 6)) begin
            errors++;
            $display("FAIL stall_word%0d en=%h d=%h ptr=%0d fd=%b want %h/%h/%0d/%b",
                     i, en, d, ptr, frame_done, exp_en, 32'hB0 + 32'(i), exp_ptr, (i == 6));
         end
         step();
         checks++;
         if (en !== 7'h00 || ptr !== exp_ptr || frame_done !== 1'b0 || d !== 32'hB0 + 32'(i)) begin
            errors++;
            $display("FAIL stall_gap%0d en=%h ptr=%0d fd=%b d=%h want 00/%0d/0/%h",
                     i, en, ptr, frame_done, d, exp_ptr, 32'hB0 + 32'(i));
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_end busy=%b want 0", busy);
      end
   endtask

   task automatic test_single();
      w_valid = 1'b1; w_addr = 3'd3; w_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (w_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready w_ready=%b want 1", w_ready);
      end
      step();
      w_valid = 1'b0;
      checks++;
      if (en !== 7'h08 || d !== 32'hDEADBEEF || addr_err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_write en=%h d=%h ae=%b busy=%b want 08/deadbeef/0/0", en, d, addr_err, busy);
      end
      step();
      checks++;
      if (en !== 7'h00 || d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_hold en=%h d=%h want 00/deadbeef", en, d);
      end
      w_valid = 1'b1; w_addr = 3'd7; w_data = 32'h12345678;
      step();
      w_valid = 1'b0;
      checks++;
      if (en !== 7'h00 || addr_err !== 1'b1 || d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_bad_addr en=%h ae=%b d=%h want 00/1/deadbeef", en, addr_err, d);
      end
      step();
      checks++;
      if (addr_err !== 1'b0 || en !== 7'h00) begin
         errors++;
         $display("FAIL single_err_pulse ae=%b en=%h want 0/00", addr_err, en);
      end
   endtask

   task automatic test_abort();
      start = 1'b1;
      step();
      start = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 32'hC0 + 32'(i);
         step();
      end
      checks++;
      if (ptr !== 3'd3 || en !== 7'h04 || d !== 32'hC2) begin
         errors++;
         $display("FAIL abort_pre ptr=%0d en=%h d=%h want 3/04/c2", ptr, en, d);
      end
      abort = 1'b1; s_data = 32'hC3;
      step();
      abort = 1'b0; s_valid = 1'b0;
      checks++;
      if (en !== 7'h00 || ptr !== 3'd0 || frame_done !== 1'b0 || busy !== 1'b0 || d !== 32'hC2) begin
         errors++;
         $display("FAIL abort_cycle en=%h ptr=%0d fd=%b busy=%b d=%h want 00/0/0/0/c2", en, ptr, frame_done, busy, d);
      end
      step();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_after fd=%b busy=%b want 0/0", frame_done, busy);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      s_valid = 1'b1; s_data = 32'hD0;
      step();
      s_valid = 1'b0;
      checks++;
      if (en !== 7'h01 || d !== 32'hD0 || ptr !== 3'd1) begin
         errors++;
         $display("FAIL abort_restart en=%h d=%h ptr=%0d want 01/d0/1", en, d, ptr);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      step();
      start = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_data = 32'hE0 + 32'(i);
         step();
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1; s_valid = 1'b0;
      #1;
      checks++;
      if (en !== 7'h00 || d !== 32'h0 || ptr !== 3'd0 || frame_done !== 1'b0 || addr_err !== 1'b0 ||
          s_ready !== 1'b0 || w_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid en=%h d=%h ptr=%0d fd=%b ae=%b sr=%b wr=%b busy=%b want 00/0/0/0/0/0/1/0",
                  en, d, ptr, frame_done, addr_err, s_ready, w_ready, busy);
      end
   endtask

   task automatic test_start_vs_write();
      start = 1'b1; w_valid = 1'b1; w_addr = 3'd2; w_data = 32'h55AA55AA;
      #1;
      checks++;
      if (w_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_w_ready w_ready=%b want 0", w_ready);
      end
      step();
      start = 1'b0; w_valid = 1'b0;
      checks++;
      if (en !== 7'h00 || d !== 32'h0 || busy !== 1'b1 || s_ready !== 1'b1 || ptr !== 3'd0) begin
         errors++;
         $display("FAIL start_w_frame en=%h d=%h busy=%b sr=%b ptr=%0d want 00/0/1/1/0", en, d, busy, s_ready, ptr);
      end
   endtask

   task automatic test_back_to_back();
      s_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         s_data = 32'hF0 + 32'(i);
         step();
      end
      s_valid = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      s_valid = 1'b1; s_data = 32'h77;
      step();
      s_valid = 1'b0;
      checks++;
      if (en !== 7'h01 || d !== 32'h77 || ptr !== 3'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second en=%h d=%h ptr=%0d busy=%b want 01/77/1/1", en, d, ptr, busy);
      end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_stall();
      test_single();
      test_abort();
      test_reset_mid();
      test_start_vs_write();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
